// File: rtl/module_ascii_frame_tx.sv
// ---------------------------------------------------------------------------
// module_ascii_frame_tx
// Streams a captured three-digit ASCII number (hundreds, tens, units), with
// an optional CR LF trailer, one byte at a time into a UART transmitter over
// a valid/ready byte interface. The digits are snapshotted on a frame request.
// Non-decimal codes are replaced by '?', and leading zeros can be blanked.
//
// Parameters:
//   SEND_CRLF    1: append 0x0D 0x0A (5-byte frame), 0: 3-byte frame
//   BLANK_ZEROS  1: leading '0' characters are sent as space (0x20)
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           frame request pulse, honoured only while idle
//   ascii_centenas  hundreds character
//   ascii_decenas   tens character
//   ascii_unidades  units character
//   tx_data         byte presented to the UART transmitter
//   tx_valid        tx_data holds a valid byte
//   tx_ready        transmitter accepts the byte this cycle
//   busy            frame in progress
//   done            one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module module_ascii_frame_tx #(
    parameter int unsigned SEND_CRLF   = 1,
    parameter int unsigned BLANK_ZEROS = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] ascii_centenas,
    input  logic [7:0] ascii_decenas,
    input  logic [7:0] ascii_unidades,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = (SEND_CRLF != 0) ? IDX_W'(4) : IDX_W'(2);

    localparam logic [BYTE_W-1:0] CH_ZERO  = 8'h30;
    localparam logic [BYTE_W-1:0] CH_NINE  = 8'h39;
    localparam logic [BYTE_W-1:0] CH_QUERY = 8'h3F;
    localparam logic [BYTE_W-1:0] CH_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] CH_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] CH_LF    = 8'h0A;

    // Anything that is not a decimal digit is reported as '?'.
    function automatic logic [BYTE_W-1:0] sanitize(input logic [BYTE_W-1:0] ch);
        return ((ch >= CH_ZERO) && (ch <= CH_NINE)) ? ch : CH_QUERY;
    endfunction

    // Byte at a given frame position.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] hun,
        input logic [BYTE_W-1:0] ten,
        input logic [BYTE_W-1:0] uni
    );
        logic [BYTE_W-1:0] b;
        case (idx)
            IDX_W'(0): b = hun;
            IDX_W'(1): b = ten;
            IDX_W'(2): b = uni;
            IDX_W'(3): b = CH_CR;
            IDX_W'(4): b = CH_LF;
            default:   b = '0;
        endcase
        return b;
    endfunction

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [BYTE_W-1:0] r_snap_h;
    logic [BYTE_W-1:0] r_snap_t;
    logic [BYTE_W-1:0] r_snap_u;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;

    logic [0:0]        w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  w_idx_inc;
    logic [BYTE_W-1:0] w_snap_h_nxt;
    logic [BYTE_W-1:0] w_snap_t_nxt;
    logic [BYTE_W-1:0] w_snap_u_nxt;
    logic [BYTE_W-1:0] w_tx_data_nxt;
    logic              w_tx_valid_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic [BYTE_W-1:0] w_san_h;
    logic [BYTE_W-1:0] w_san_t;
    logic [BYTE_W-1:0] w_san_u;
    logic [BYTE_W-1:0] w_cap_h;
    logic [BYTE_W-1:0] w_cap_t;
    logic              w_xfer;

    // Capture path: sanitise, then blank leading zeros. A '?' in the hundreds
    // position is not '0', so it naturally stops blanking of the tens digit.
    always_comb begin
        w_san_h = sanitize(ascii_centenas);
        w_san_t = sanitize(ascii_decenas);
        w_san_u = sanitize(ascii_unidades);
        w_cap_h = w_san_h;
        w_cap_t = w_san_t;
        if (BLANK_ZEROS != 0) begin
            if (w_san_h == CH_ZERO) begin
                w_cap_h = CH_SPACE;
                if (w_san_t == CH_ZERO) begin
                    w_cap_t = CH_SPACE;
                end
            end
        end
    end

    assign w_xfer    = r_tx_valid & tx_ready;
    assign w_idx_inc = r_idx + IDX_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_snap_h_nxt   = r_snap_h;
        w_snap_t_nxt   = r_snap_t;
        w_snap_u_nxt   = r_snap_u;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_snap_h_nxt   = w_cap_h;
                    w_snap_t_nxt   = w_cap_t;
                    w_snap_u_nxt   = w_san_u;
                    w_idx_nxt      = '0;
                    w_state_nxt    = ST_SEND;
                    w_tx_valid_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_tx_data_nxt  = w_cap_h;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt    = ST_IDLE;
                        w_idx_nxt      = '0;
                        w_tx_valid_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_idx_nxt     = w_idx_inc;
                        w_tx_data_nxt = frame_byte(w_idx_inc, r_snap_h, r_snap_t, r_snap_u);
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_tx_valid_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_snap_h   <= '0;
            r_snap_t   <= '0;
            r_snap_u   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_snap_h   <= w_snap_h_nxt;
            r_snap_t   <= w_snap_t_nxt;
            r_snap_u   <= w_snap_u_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_module_ascii_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_module_ascii_frame_tx
// Three instances share one stimulus stream:
//   [0] SEND_CRLF=1 BLANK_ZEROS=0, [1] SEND_CRLF=1 BLANK_ZEROS=1,
//   [2] SEND_CRLF=0 BLANK_ZEROS=0.
// A frame-level reference model (byte list + position) predicts each output.
// ---------------------------------------------------------------------------
module tb_module_ascii_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_c;
    logic [7:0] a_d;
    logic [7:0] a_u;
    logic       tx_ready;

    logic [7:0] d_data  [3];
    logic       d_valid [3];
    logic       d_busy  [3];
    logic       d_done  [3];

    int checks   = 0;
    int failures = 0;

    module_ascii_frame_tx #(.SEND_CRLF(1), .BLANK_ZEROS(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ascii_centenas(a_c), .ascii_decenas(a_d), .ascii_unidades(a_u),
        .tx_data(d_data[0]), .tx_valid(d_valid[0]), .tx_ready(tx_ready),
        .busy(d_busy[0]), .done(d_done[0])
    );

    module_ascii_frame_tx #(.SEND_CRLF(1), .BLANK_ZEROS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ascii_centenas(a_c), .ascii_decenas(a_d), .ascii_unidades(a_u),
        .tx_data(d_data[1]), .tx_valid(d_valid[1]), .tx_ready(tx_ready),
        .busy(d_busy[1]), .done(d_done[1])
    );

    module_ascii_frame_tx #(.SEND_CRLF(0), .BLANK_ZEROS(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ascii_centenas(a_c), .ascii_decenas(a_d), .ascii_unidades(a_u),
        .tx_data(d_data[2]), .tx_valid(d_valid[2]), .tx_ready(tx_ready),
        .busy(d_busy[2]), .done(d_done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic       m_blank [3] = '{1'b0, 1'b1, 1'b0};
    logic       m_crlf  [3] = '{1'b1, 1'b1, 1'b0};
    logic       m_act   [3];
    logic       m_done  [3];
    int         m_idx   [3];
    int         m_len   [3];
    logic [7:0] m_bytes [3][5];

    logic [7:0] lg [3][$];
    int         done_cnt [3];

    function automatic logic [7:0] san(input logic [7:0] x);
        return (x >= 8'h30 && x <= 8'h39) ? x : 8'h3F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
            m_idx[i]  = 0;
            m_len[i]  = 0;
            for (int k = 0; k < 5; k++) m_bytes[i][k] = 8'h00;
        end
    endtask

    // Builds the frame a start request would send, from the character rules.
    task automatic model_build(input int i);
        logic [7:0] h, t, u;
        h = san(a_c);
        t = san(a_d);
        u = san(a_u);
        if (m_blank[i]) begin
            if (san(a_c) == 8'h30) h = 8'h20;
            if (san(a_c) == 8'h30 && san(a_d) == 8'h30) t = 8'h20;
        end
        m_bytes[i][0] = h;
        m_bytes[i][1] = t;
        m_bytes[i][2] = u;
        m_bytes[i][3] = 8'h0D;
        m_bytes[i][4] = 8'h0A;
        m_len[i] = m_crlf[i] ? 5 : 3;
        m_idx[i] = 0;
        m_act[i] = 1'b1;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (m_act[i]) begin
                m_done[i] = 1'b0;
                if (tx_ready) begin
                    m_idx[i]++;
                    if (m_idx[i] == m_len[i]) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end else begin
                m_done[i] = 1'b0;
                if (start) model_build(i);
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid[%0d]", i), 32'(d_valid[i]), 32'(m_act[i]));
            chk($sformatf("busy[%0d]", i),  32'(d_busy[i]),  32'(m_act[i]));
            chk($sformatf("done[%0d]", i),  32'(d_done[i]),  32'(m_done[i]));
            if (m_act[i])
                chk($sformatf("data[%0d] pos%0d", i, m_idx[i]), 32'(d_data[i]), 32'(m_bytes[i][m_idx[i]]));
            if (d_done[i]) done_cnt[i]++;
        end
    endtask

    // One clock: log accepted bytes, advance model, check outputs after edge.
    task automatic step();
        for (int i = 0; i < 3; i++)
            if (d_valid[i] && tx_ready) lg[i].push_back(d_data[i]);
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic pulse_start(input logic [7:0] c, input logic [7:0] d, input logic [7:0] u);
        a_c = c; a_d = d; a_u = u;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || m_act[2]) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
        step();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            lg[i].delete();
            done_cnt[i] = 0;
        end
    endtask

    // Compares the accepted-byte log of instance i with an expected list
    // packed first byte most significant.
    task automatic chk_log(input int i, input string tag, input logic [63:0] exp, input int n);
        chk({tag, "_count"}, 32'(lg[i].size()), 32'(n));
        for (int k = 0; k < n && k < lg[i].size(); k++)
            chk($sformatf("%s_b%0d", tag, k), 32'(lg[i][k]), 32'(exp[8*(n-1-k) +: 8]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_valid[%0d]", tag, i), 32'(d_valid[i]), 32'd0);
            chk($sformatf("%s_busy[%0d]", tag, i),  32'(d_busy[i]),  32'd0);
            chk($sformatf("%s_done[%0d]", tag, i),  32'(d_done[i]),  32'd0);
            chk($sformatf("%s_data[%0d]", tag, i),  32'(d_data[i]),  32'h00);
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; tx_ready = 1'b0;
        a_c = 8'h00; a_d = 8'h00; a_u = 8'h00;
        model_reset();
        clear_logs();

        // Reset state
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        compare();

        // Basic frame, ready held high
        tx_ready = 1'b1;
        clear_logs();
        pulse_start(8'h31, 8'h32, 8'h33);
        run_until_idle(20);
        chk_log(0, "basic_a", 64'h31_32_33_0D_0A, 5);
        chk_log(2, "basic_c", 64'h31_32_33, 3);
        chk("basic_done_a", 32'(done_cnt[0]), 32'd1);

        // Backpressure, snapshot and start ignored mid-frame
        clear_logs();
        tx_ready = 1'b1;
        pulse_start(8'h31, 8'h32, 8'h33);
        tx_ready = 1'b0; step();
        a_c = 8'h39; a_d = 8'h39; a_u = 8'h39;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 30 && (m_act[0] || m_act[1] || m_act[2]); k++) begin
            tx_ready = (k % 3 == 0);
            step();
        end
        tx_ready = 1'b1;
        run_until_idle(20);
        chk_log(0, "bp_a", 64'h31_32_33_0D_0A, 5);
        chk_log(2, "bp_c", 64'h31_32_33, 3);
        chk("bp_done_a", 32'(done_cnt[0]), 32'd1);

        // Blanking
        clear_logs();
        pulse_start(8'h30, 8'h30, 8'h30);
        run_until_idle(20);
        chk_log(1, "blank000", 64'h20_20_30_0D_0A, 5);
        chk_log(0, "noblank000", 64'h30_30_30_0D_0A, 5);
        clear_logs();
        pulse_start(8'h30, 8'h35, 8'h30);
        run_until_idle(20);
        chk_log(1, "blank050", 64'h20_35_30_0D_0A, 5);
        clear_logs();
        pulse_start(8'h30, 8'h3A, 8'h30);
        run_until_idle(20);
        chk_log(1, "blank0q0", 64'h20_3F_30_0D_0A, 5);
        chk_log(2, "sanit_c", 64'h30_3F_30, 3);

        // No CRLF with restart on the done cycle
        clear_logs();
        pulse_start(8'h37, 8'h30, 8'h34);
        for (int k = 0; k < 10 && !m_done[2]; k++) step();
        chk("nocrlf_done_c", 32'(d_done[2]), 32'd1);
        pulse_start(8'h35, 8'h36, 8'h38);
        chk("restart_valid_c", 32'(d_valid[2]), 32'd1);
        chk("restart_data_c", 32'(d_data[2]), 32'h35);
        run_until_idle(20);
        chk_log(2, "nocrlf_c", 64'h37_30_34_35_36_38, 6);
        chk_log(0, "nocrlf_a", 64'h37_30_34_0D_0A, 5);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            start    = ($urandom_range(0, 3) == 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            a_c = ($urandom_range(0, 1) == 0) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'($urandom_range(0, 255));
            a_d = ($urandom_range(0, 2) == 0) ? 8'h30 : 8'(8'h2F + $urandom_range(0, 12));
            a_u = 8'(8'h2E + $urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) a_c = 8'h30;
            step();
        end
        start = 1'b0;
        tx_ready = 1'b1;
        run_until_idle(20);

        // Reset in the middle of a frame
        clear_logs();
        tx_ready = 1'b1;
        pulse_start(8'h31, 8'h32, 8'h33);
        step();
        step();
        chk("pre_reset_xfers", 32'(lg[0].size()), 32'd2);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_valid[%0d]", i), 32'(d_valid[i]), 32'd0);
            chk($sformatf("midrst_busy[%0d]", i),  32'(d_busy[i]),  32'd0);
            chk($sformatf("midrst_done[%0d]", i),  32'(d_done[i]),  32'd0);
        end
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        pulse_start(8'h34, 8'h35, 8'h36);
        run_until_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
